soc_system_sysid_checker: RTL and testbench
===========================================

SOC_SYSTEM_SYSID_CHECKER -- requirements
Module: soc_system_sysid_checker

Interface
REQ-001 The block SHALL provide these parameters:
- EXPECTED_ID, 32'hACD51302, system ID value expected at address 0.
- EXPECTED_TS, 32'h591C4BB7, build timestamp expected at address 1.
- TIMEOUT_CYCLES, 16'd1023, maximum cycles allowed per read transaction before abort.
- AUTO_START, 1, when 1 a check starts automatically on the first cycle after reset release.

REQ-002 The block SHALL provide these ports (clock and reset first):
- clock, in, 1, single clock for all logic.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle pulse that requests a check.
- avm_address, out, 1, Avalon-MM master word address (0 = ID, 1 = timestamp).
- avm_read, out, 1, Avalon-MM read request.
- avm_waitrequest, in, 1, slave stall; a request is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
- avm_readdatavalid, in, 1, read data valid strobe.
- avm_readdata, in, 32, read data.
- busy, out, 1, check in progress.
- done, out, 1, one-cycle pulse when a check completes or aborts.
- id_value, out, 32, last ID word captured.
- ts_value, out, 32, last timestamp word captured.
- id_ok, out, 1, id_value == EXPECTED_ID.
- ts_ok, out, 1, ts_value == EXPECTED_TS.
- timeout_err, out, 1, last check aborted on timeout.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FINISH.
REQ-004 In IDLE, a start pulse, or the first post-reset cycle when AUTO_START=1, SHALL move the FSM to ID_REQ, clear id_ok, ts_ok and timeout_err, and assert busy from the next cycle.
REQ-005 In ID_REQ the block SHALL drive avm_read=1 and avm_address=0, and hold both until the request is accepted.
REQ-006 On acceptance in ID_REQ, the FSM SHALL go to ID_WAIT with avm_read=0.
- If avm_readdatavalid is also 1 in the acceptance cycle (zero-latency slave), the FSM SHALL capture the data and go directly to TS_REQ.
REQ-007 In ID_WAIT, on avm_readdatavalid=1 the block SHALL latch avm_readdata into id_value, set id_ok to the comparison result in the same register update, and go to TS_REQ.
REQ-008 TS_REQ and TS_WAIT SHALL behave as ID_REQ and ID_WAIT, with these differences:
- avm_address=1.
- Data is captured into ts_value and ts_ok is updated.
- The FSM goes to FINISH.
REQ-009 In FINISH, done SHALL be 1 for exactly one cycle, busy SHALL deassert in that same cycle, and the FSM SHALL return to IDLE.
REQ-010 A 16-bit timeout counter SHALL clear on entry to each REQ state and increment every cycle in the REQ and WAIT states.
- When the counter reaches TIMEOUT_CYCLES without data, the block SHALL set timeout_err=1, drop avm_read and go to FINISH.
- id_ok and ts_ok SHALL reflect only the words actually captured.
REQ-011 A start pulse while busy=1 SHALL be ignored; a start pulse in the FINISH cycle SHALL also be ignored.
REQ-012 avm_readdatavalid SHALL be ignored in IDLE, TS_REQ before acceptance, and FINISH.
REQ-013 avm_address SHALL be stable whenever avm_read=1 and avm_waitrequest=1.
REQ-014 At most one read SHALL be outstanding at any time.
REQ-015 id_value, ts_value, id_ok and ts_ok SHALL hold their values in IDLE until the next check begins.

Reset
REQ-016 Assertion of reset_n=0 SHALL asynchronously force:
- the FSM to IDLE;
- avm_read, busy, done, id_ok, ts_ok and timeout_err to 0;
- avm_address to 0;
- id_value, ts_value and the timeout counter to 0.
REQ-017 Reset asserted mid-transaction SHALL abort the transaction with no done pulse.
- After release, an AUTO_START=1 instance SHALL restart from ID_REQ.
REQ-018 An auto-start request SHALL be registered from reset release, so avm_read first asserts on the second rising edge after reset_n goes high.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Zero-latency slave returns 0xACD51302/0x591C4BB7 combinationally -> done after the second read; id_ok=1, ts_ok=1, timeout_err=0; busy high for 2-4 cycles.
- waitrequest held for 3 cycles per read, readdatavalid 2 cycles after accept -> address stable while stalled; correct values captured; one done pulse.
- Timestamp read returns 0x12345678 -> id_ok=1, ts_ok=0, ts_value=0x12345678.
- No readdatavalid on the ID read, with TIMEOUT_CYCLES=8 -> timeout_err=1 and done exactly 8 cycles after ID_REQ entry; no timestamp read is issued.
- reset_n pulsed low during TS_WAIT -> all outputs 0 immediately; no done pulse; a fresh check starts after release.
- start pulsed while busy and again in the FINISH cycle -> exactly one check runs (a single done pulse).

Source files
------------

// File: rtl/soc_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// soc_system_sysid_checker
//
// Reads the two words of a system-ID peripheral over an Avalon-MM master port
// (word 0 = system ID, word 1 = build timestamp) and compares them with the
// values this build expects. A check is started by a start pulse, or
// automatically once after reset release when AUTO_START is set.
//
// Handshake: a read request is accepted on a rising edge where
// avm_read = 1 and avm_waitrequest = 0. Until acceptance, avm_read and
// avm_address are held constant. Read data is taken on a rising edge where
// avm_readdatavalid = 1 while a read is outstanding, including the acceptance
// edge itself for a zero-latency slave. At most one read is outstanding.
//
// Ports:
//   clock              single clock for all logic
//   reset_n            asynchronous active-low reset
//   start              single-cycle pulse requesting a check (ignored while busy
//                      and in the FINISH cycle)
//   avm_address        word address (0 = ID, 1 = timestamp)
//   avm_read           read request
//   avm_waitrequest    slave stall
//   avm_readdatavalid  read data valid strobe
//   avm_readdata       read data
//   busy               check in progress
//   done               one-cycle pulse when a check completes or aborts
//   id_value           last ID word captured
//   ts_value           last timestamp word captured
//   id_ok              id_value matched EXPECTED_ID in the last check
//   ts_ok              ts_value matched EXPECTED_TS in the last check
//   timeout_err        last check aborted because a read timed out
//   state_dbg          current FSM state encoding (debug / checker binding)
// -----------------------------------------------------------------------------
module soc_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS    = 32'h591C4BB7,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1023,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] tmo_cnt;

    // Auto-start is a two-stage affair: auto_armed is set by reset, and on the
    // first edge after release it moves into auto_req. IDLE acts on auto_req at
    // the second edge, so avm_read first rises on the second edge after
    // release and never sooner.
    logic        auto_armed;
    logic        auto_req;

    // Request accepted this cycle (only meaningful in the REQ states, where
    // avm_read is always high).
    logic        accept;
    // The counter is about to reach TIMEOUT_CYCLES with this increment.
    logic        tmo_hit;

    assign accept    = avm_read && !avm_waitrequest;
    assign tmo_hit   = (tmo_cnt == (TIMEOUT_CYCLES - 16'd1));
    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            tmo_cnt     <= 16'd0;
            auto_armed  <= AUTO_START;
            auto_req    <= 1'b0;
        end else begin
            done       <= 1'b0;
            auto_armed <= 1'b0;
            auto_req   <= auto_armed;

            case (state)
                IDLE: begin
                    // Captured values and flags hold here until a new check.
                    if (start || auto_req) begin
                        state       <= ID_REQ;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b1;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout_err <= 1'b0;
                        tmo_cnt     <= 16'd0;
                    end
                end

                ID_REQ: begin
                    if (accept && avm_readdatavalid) begin
                        // Zero-latency slave: data arrives with acceptance,
                        // go straight on to the timestamp request.
                        id_value    <= avm_readdata;
                        id_ok       <= (avm_readdata == EXPECTED_ID);
                        state       <= TS_REQ;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b1;
                        tmo_cnt     <= 16'd0;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                        tmo_cnt     <= tmo_cnt + 16'd1;
                    end else if (accept) begin
                        avm_read <= 1'b0;
                        state    <= ID_WAIT;
                        tmo_cnt  <= tmo_cnt + 16'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                ID_WAIT: begin
                    if (avm_readdatavalid) begin
                        id_value    <= avm_readdata;
                        id_ok       <= (avm_readdata == EXPECTED_ID);
                        state       <= TS_REQ;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b1;
                        tmo_cnt     <= 16'd0;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                        tmo_cnt     <= tmo_cnt + 16'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                TS_REQ: begin
                    if (accept && avm_readdatavalid) begin
                        ts_value    <= avm_readdata;
                        ts_ok       <= (avm_readdata == EXPECTED_TS);
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                        tmo_cnt     <= tmo_cnt + 16'd1;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                        tmo_cnt     <= tmo_cnt + 16'd1;
                    end else if (accept) begin
                        avm_read <= 1'b0;
                        state    <= TS_WAIT;
                        tmo_cnt  <= tmo_cnt + 16'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                TS_WAIT: begin
                    if (avm_readdatavalid) begin
                        ts_value    <= avm_readdata;
                        ts_ok       <= (avm_readdata == EXPECTED_TS);
                        avm_address <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                        tmo_cnt     <= tmo_cnt + 16'd1;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                        tmo_cnt     <= tmo_cnt + 16'd1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                FINISH: begin
                    // done is high for this one cycle; start is not looked at.
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_soc_system_sysid_checker
//
// Directed bench for soc_system_sysid_checker (TIMEOUT_CYCLES = 8). A
// behavioural Avalon-MM slave with configurable stall and read latency answers
// the DUT. Expected check results are queued when a check is launched and
// compared when done pulses.
// -----------------------------------------------------------------------------
module tb_soc_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'hACD51302;
    localparam logic [31:0] EXP_TS = 32'h591C4BB7;
    localparam int          W      = 67;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [2:0]  state_dbg;

    always #5 clock = ~clock;

    soc_system_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (16'd8),
        .AUTO_START     (1'b1)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .busy              (busy),
        .done              (done),
        .id_value          (id_value),
        .ts_value          (ts_value),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout_err       (timeout_err),
        .state_dbg         (state_dbg)
    );

    // ------------------------------------------------------------------
    // Counters and check helper
    // ------------------------------------------------------------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: {timeout_err, ts_ok, id_ok, ts_value, id_value}
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    int           done_count = 0;

    function automatic logic [W-1:0] pack_exp(input logic to, input logic tso, input logic ido,
                                              input logic [31:0] ts, input logic [31:0] id);
        return {to, tso, ido, ts, id};
    endfunction

    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && done === 1'b1) begin
                done_count++;
                chk("sb_pending", {31'd0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_timeout_err", {31'd0, timeout_err}, {31'd0, e[66]});
                    chk("sb_ts_ok",       {31'd0, ts_ok},       {31'd0, e[65]});
                    chk("sb_id_ok",       {31'd0, id_ok},       {31'd0, e[64]});
                    chk("sb_ts_value",    ts_value,             e[63:32]);
                    chk("sb_id_value",    id_value,             e[31:0]);
                    chk("sb_busy_low",    {31'd0, busy},        32'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Behavioural Avalon-MM slave
    // ------------------------------------------------------------------
    int          cfg_stall   = 0;
    int          cfg_lat     = 0;
    bit          cfg_id_drop = 1'b0;
    logic [31:0] cfg_id_data = EXP_ID;
    logic [31:0] cfg_ts_data = EXP_TS;

    int   stall_cnt = 0;
    int   lat_left  = 0;
    bit   stalled   = 1'b0;
    logic stall_addr;
    logic pend_addr;
    int   id_reads  = 0;
    int   ts_reads  = 0;

    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'd0;
        forever begin
            @(negedge clock);
            avm_readdatavalid = 1'b0;
            if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_addr ? cfg_ts_data : cfg_id_data;
                end
            end
            if (reset_n === 1'b1 && avm_read === 1'b1) begin
                if (stalled) chk("addr_stable", {31'd0, avm_address}, {31'd0, stall_addr});
                if (stall_cnt < cfg_stall) begin
                    avm_waitrequest = 1'b1;
                    stall_cnt++;
                    stalled    = 1'b1;
                    stall_addr = avm_address;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt       = 0;
                    stalled         = 1'b0;
                    chk("one_outstanding", lat_left, 32'd0);
                    if (avm_address) ts_reads++;
                    else             id_reads++;
                    if (cfg_lat == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = avm_address ? cfg_ts_data : cfg_id_data;
                    end else if (!(cfg_id_drop && !avm_address)) begin
                        lat_left  = cfg_lat;
                        pend_addr = avm_address;
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt       = 0;
                stalled         = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver task: pulse start (optionally again at cycle repulse_at) and
    // wait for done. cycles counts negedges after the start pulse was set.
    // ------------------------------------------------------------------
    task automatic run_check(input int repulse_at, output int cycles, output int busy_n);
        start  = 1'b1;
        cycles = 0;
        busy_n = 0;
        forever begin
            @(negedge clock);
            cycles++;
            if (cycles == 1 || (repulse_at != 0 && cycles == repulse_at + 1)) start = 1'b0;
            if (repulse_at != 0 && cycles == repulse_at) start = 1'b1;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1 || cycles >= 200) break;
        end
        start = 1'b0;
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int cyc;
        int bsy;
        int dc;
        int tsr;
        int k;

        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_avm_read",    {31'd0, avm_read},    32'd0);
        chk("rst_avm_address", {31'd0, avm_address}, 32'd0);
        chk("rst_busy",        {31'd0, busy},        32'd0);
        chk("rst_done",        {31'd0, done},        32'd0);
        chk("rst_id_value",    id_value,             32'd0);
        chk("rst_ts_value",    ts_value,             32'd0);
        chk("rst_flags",       {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
        chk("rst_state",       {29'd0, state_dbg},   32'd0);

        // 1: auto-start with a zero-latency slave
        cfg_stall = 0; cfg_lat = 0;
        exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b1, EXP_TS, EXP_ID));
        reset_n = 1'b1;
        @(negedge clock);
        chk("auto_read_edge1", {31'd0, avm_read}, 32'd0);
        @(negedge clock);
        chk("auto_read_edge2", {31'd0, avm_read}, 32'd1);
        chk("auto_addr_id",    {31'd0, avm_address}, 32'd0);
        bsy = 1;
        k   = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
            if (busy === 1'b1) bsy++;
        end
        chk("zl_done_seen", {31'd0, done}, 32'd1);
        chk("zl_busy_2to4", {31'd0, (bsy >= 2 && bsy <= 4)}, 32'd1);
        repeat (3) @(negedge clock);

        // 2: three-cycle stall per read, data two cycles after accept
        cfg_stall = 3; cfg_lat = 2;
        dc = done_count;
        exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b1, EXP_TS, EXP_ID));
        run_check(0, cyc, bsy);
        repeat (5) @(negedge clock);
        chk("stall_one_done", done_count, dc + 1);

        // 3: wrong timestamp word
        cfg_stall = 0; cfg_lat = 1;
        cfg_ts_data = 32'h12345678;
        exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b1, 32'h12345678, EXP_ID));
        run_check(0, cyc, bsy);
        repeat (3) @(negedge clock);
        chk("hold_ts_value", ts_value, 32'h12345678);

        // 4: ID read never returns data -> timeout after 8 cycles
        cfg_id_drop = 1'b1;
        tsr = ts_reads;
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 32'h12345678, EXP_ID));
        run_check(0, cyc, bsy);
        chk("tmo_done_latency", cyc, 32'd9);
        repeat (4) @(negedge clock);
        chk("tmo_no_ts_read", ts_reads, tsr);
        chk("tmo_err_held", {31'd0, timeout_err}, 32'd1);
        cfg_id_drop = 1'b0;
        cfg_ts_data = EXP_TS;

        // 5: reset during TS_WAIT, then auto restart
        cfg_stall = 0; cfg_lat = 4;
        exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b1, EXP_TS, EXP_ID));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (state_dbg !== 3'd4 && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("reach_ts_wait", {29'd0, state_dbg}, 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_read",  {31'd0, avm_read},    32'd0);
        chk("mid_rst_addr",  {31'd0, avm_address}, 32'd0);
        chk("mid_rst_busy",  {31'd0, busy},        32'd0);
        chk("mid_rst_done",  {31'd0, done},        32'd0);
        chk("mid_rst_id",    id_value,             32'd0);
        chk("mid_rst_ts",    ts_value,             32'd0);
        chk("mid_rst_flags", {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
        exp_q.delete();
        lat_left  = 0;
        stall_cnt = 0;
        stalled   = 1'b0;
        dc = done_count;
        exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b1, EXP_TS, EXP_ID));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("restart_done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clock);
        chk("rst_single_done", done_count, dc + 1);

        // 6: start while busy and in the FINISH cycle are ignored
        cfg_stall = 1; cfg_lat = 1;
        dc = done_count;
        exp_q.push_back(pack_exp(1'b0, 1'b1, 1'b1, EXP_TS, EXP_ID));
        run_check(3, cyc, bsy);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (20) @(negedge clock);
        chk("ignored_starts_one_done", done_count, dc + 1);
        chk("ignored_starts_idle", {29'd0, state_dbg}, 32'd0);
        chk("ignored_starts_busy", {31'd0, busy}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
